// File: rtl/mapper_mem_access_pkg.sv
// Shared types and constants for the mapper memory access stage.
package mapper_mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         TIMEOUT_DEFAULT = 255;
    localparam logic [7:0] UNMAPPED_RD     = 8'hFF;

endpackage

// File: rtl/mapper_mem_access_cache.sv
// One-entry last-read cache: combinational hit compare, fill on next edge.
// Flush and write-address invalidate win over fill; never stalls.
module mem_last_read_cache #(
    parameter int ADDR_W = 27
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              hit_o,
    output logic [7:0]        rd_data_o,
    input  logic              fill_i,
    input  logic [ADDR_W-1:0] fill_addr_i,
    input  logic [7:0]        fill_data_i,
    input  logic              inval_i,
    input  logic [ADDR_W-1:0] inval_addr_i,
    input  logic              flush_i
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;

    assign hit_o     = valid_q && (lookup_addr_i == addr_q);
    assign rd_data_o = data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            if (fill_i) begin
                addr_q <= fill_addr_i;
                data_q <= fill_data_i;
            end
            if (flush_i || (inval_i && (inval_addr_i == addr_q))) begin
                valid_q <= 1'b0;
            end else if (fill_i) begin
                valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mapper_mem_access.sv
// CPU memory cycle to SDRAM req/ack bridge with last-read cache; hit valid at N+1, miss valid at ack+1.
// cpu_wait stalls the CPU from the request cycle until the SDRAM ack (or timeout abort).
module mapper_mem_access
    import mapper_mem_access_pkg::*;
#(
    parameter int ADDR_W  = 27,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_din,
    input  logic              ram_cs,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_wr_en,
    input  logic              cache_flush,
    output logic              cpu_wait,
    output logic [7:0]        cpu_dout,
    output logic              cpu_dout_valid,
    output logic              sdram_req,
    output logic              sdram_we,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [7:0]        sdram_din,
    input  logic              sdram_ack,
    input  logic [7:0]        sdram_dout,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rd_q;
    logic              flush_pend_q;
    logic              sdram_req_q;
    logic              sdram_we_q;
    logic [ADDR_W-1:0] sdram_addr_q;
    logic [7:0]        sdram_din_q;
    logic [7:0]        cpu_dout_q;
    logic              dout_vld_q;
    logic              timeout_q;

    logic              start;
    logic              lookup_hit;
    logic              cache_hit;
    logic              miss_start;
    logic [7:0]        cache_data;
    logic              fill;
    logic              inval;

    assign start      = (state_q == IDLE) && cpu_req && ram_cs && (cpu_rd || (cpu_wr && ram_wr_en));
    assign cache_hit  = start && cpu_rd && lookup_hit;
    assign miss_start = start && !cache_hit;
    // Combinational so the CPU is held in the very cycle it raises the request.
    assign cpu_wait   = miss_start || (state_q == REQ);

    assign fill  = (state_q == REQ) && sdram_ack && rd_q && !flush_pend_q && !cache_flush;
    assign inval = miss_start && !cpu_rd;

    mem_last_read_cache #(
        .ADDR_W (ADDR_W)
    ) u_cache (
        .clk           (clk),
        .reset         (reset),
        .lookup_addr_i (ram_addr),
        .hit_o         (lookup_hit),
        .rd_data_o     (cache_data),
        .fill_i        (fill),
        .fill_addr_i   (sdram_addr_q),
        .fill_data_i   (sdram_dout),
        .inval_i       (inval),
        .inval_addr_i  (ram_addr),
        .flush_i       (cache_flush)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_q         <= 1'b0;
            flush_pend_q <= 1'b0;
            sdram_req_q  <= 1'b0;
            sdram_we_q   <= 1'b0;
            sdram_addr_q <= '0;
            sdram_din_q  <= '0;
            cpu_dout_q   <= UNMAPPED_RD;
            dout_vld_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            dout_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q        <= '0;
                    flush_pend_q <= 1'b0;
                    if (cache_hit) begin
                        cpu_dout_q <= cache_data;
                        dout_vld_q <= 1'b1;
                    end else if (miss_start) begin
                        sdram_req_q  <= 1'b1;
                        sdram_we_q   <= !cpu_rd;
                        sdram_addr_q <= ram_addr;
                        sdram_din_q  <= cpu_din;
                        rd_q         <= cpu_rd;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (cache_flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (sdram_ack) begin
                        sdram_req_q <= 1'b0;
                        dout_vld_q  <= rd_q;
                        if (rd_q) begin
                            cpu_dout_q <= sdram_dout;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        // Abort on the TIMEOUT-th cycle without an ack.
                        if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                            sdram_req_q <= 1'b0;
                            timeout_q   <= 1'b1;
                            cpu_dout_q  <= UNMAPPED_RD;
                            dout_vld_q  <= rd_q;
                            state_q     <= RESP;
                        end
                    end
                end
                RESP: begin
                    cnt_q        <= '0;
                    flush_pend_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_dout       = cpu_dout_q;
    assign cpu_dout_valid = dout_vld_q;
    assign sdram_req      = sdram_req_q;
    assign sdram_we       = sdram_we_q;
    assign sdram_addr     = sdram_addr_q;
    assign sdram_din      = sdram_din_q;
    assign timeout_err    = timeout_q;

    a_no_req_while_busy: assert property (@(posedge clk) disable iff (reset)
        !(cpu_req && (state_q != IDLE)));

endmodule

// File: tb/tb_mapper_mem_access.sv
// Directed and randomized CPU accesses against a transaction-level model of the access stage.
module tb_mapper_mem_access;

    localparam int ADDR_W  = 27;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_rd, cpu_wr, ram_cs, ram_wr_en, cache_flush;
    logic [7:0]        cpu_din;
    logic [ADDR_W-1:0] ram_addr;
    logic              cpu_wait, cpu_dout_valid, sdram_req, sdram_we, timeout_err;
    logic [7:0]        cpu_dout, sdram_din, sdram_dout;
    logic [ADDR_W-1:0] sdram_addr;
    logic              sdram_ack;

    always #5 clk = ~clk;

    mapper_mem_access #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_rd         (cpu_rd),
        .cpu_wr         (cpu_wr),
        .cpu_din        (cpu_din),
        .ram_cs         (ram_cs),
        .ram_addr       (ram_addr),
        .ram_wr_en      (ram_wr_en),
        .cache_flush    (cache_flush),
        .cpu_wait       (cpu_wait),
        .cpu_dout       (cpu_dout),
        .cpu_dout_valid (cpu_dout_valid),
        .sdram_req      (sdram_req),
        .sdram_we       (sdram_we),
        .sdram_addr     (sdram_addr),
        .sdram_din      (sdram_din),
        .sdram_ack      (sdram_ack),
        .sdram_dout     (sdram_dout),
        .timeout_err    (timeout_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: what the cache holds and what the CPU last saw.
    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_data;
    logic [7:0]        m_dout;
    logic              m_to;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_dout  = 8'hFF;
        m_to    = 1'b0;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; ram_cs = 1'b0; ram_wr_en = 1'b0;
        cache_flush = 1'b0; sdram_ack = 1'b0;
    endtask

    // One CPU cycle plus the observation window. ack_cyc counts cycles after the
    // request cycle (0 = never); flush_cyc likewise (0 = none).
    task automatic access(input logic rd, input logic wr, input logic cs, input logic wen,
                          input logic [ADDR_W-1:0] addr, input logic [7:0] din,
                          input int ack_cyc, input logic [7:0] ack_dout, input int flush_cyc);
        logic       start, hit, miss, tmo, flushed, bad;
        int         resp_cyc, exp_req, exp_vcyc, n_cyc, n_req, n_wait, v_cnt, v_cyc;
        logic [7:0] exp_data, v_data;

        start    = cs && (rd || (wr && wen));
        hit      = start && rd && m_valid && (addr == m_addr);
        miss     = start && !hit;
        tmo      = miss && (ack_cyc < 1 || ack_cyc > TIMEOUT);
        resp_cyc = tmo ? TIMEOUT + 1 : ack_cyc + 1;
        exp_req  = miss ? resp_cyc - 1 : 0;
        exp_vcyc = hit ? 1 : ((miss && rd) ? resp_cyc : -1);
        exp_data = hit ? m_data : (tmo ? 8'hFF : ack_dout);
        n_cyc    = miss ? resp_cyc + 1 : 2;
        flushed  = (flush_cyc >= 1) && (flush_cyc <= n_cyc);

        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_rd = rd; cpu_wr = wr; ram_cs = cs; ram_wr_en = wen;
        ram_addr = addr; cpu_din = din;
        @(negedge clk);
        check("wait_in_req_cycle", cpu_wait, miss);

        n_req = 0; n_wait = 0; v_cnt = 0; v_cyc = -1; v_data = 8'h00; bad = 1'b0;
        for (int c = 1; c <= n_cyc; c++) begin
            @(posedge clk); #1;
            cpu_req = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
            ram_cs = 1'($urandom); ram_addr = ADDR_W'($urandom); cpu_din = 8'($urandom);
            sdram_ack   = (c == ack_cyc);
            sdram_dout  = (c == ack_cyc) ? ack_dout : 8'($urandom);
            cache_flush = (c == flush_cyc);
            @(negedge clk);
            if (sdram_req) begin
                n_req++;
                if (sdram_addr !== addr || sdram_we !== !rd || (!rd && sdram_din !== din)) bad = 1'b1;
            end
            if (cpu_wait) n_wait++;
            if (cpu_dout_valid) begin
                v_cnt++;
                if (v_cyc < 0) begin
                    v_cyc  = c;
                    v_data = cpu_dout;
                end
            end
        end
        @(posedge clk); #1;
        sdram_ack = 1'b0; cache_flush = 1'b0;

        if (miss && !rd && addr == m_addr) m_valid = 1'b0;
        if (miss && rd && !tmo) begin
            m_valid = 1'b1; m_addr = addr; m_data = ack_dout;
        end
        if (flushed) m_valid = 1'b0;
        if (hit || (miss && rd)) m_dout = exp_data;
        if (tmo) begin
            m_dout = 8'hFF; m_to = 1'b1;
        end

        check("sdram_req_cycles", n_req, exp_req);
        check("cpu_wait_cycles", n_wait, exp_req);
        check("valid_strobes", v_cnt, (exp_vcyc < 0) ? 0 : 1);
        if (exp_vcyc >= 0) begin
            check("valid_cycle", v_cyc, exp_vcyc);
            check("read_data", v_data, exp_data);
        end
        check("sdram_fields", bad, 1'b0);
        check("cpu_dout_held", cpu_dout, m_dout);
        check("timeout_err", timeout_err, m_to);
    endtask

    task automatic flush_idle();
        @(posedge clk); #1 cache_flush = 1'b1;
        @(posedge clk); #1 cache_flush = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wait"},  cpu_wait, 1'b0);
        check({tag, "_dout"},  cpu_dout, 8'hFF);
        check({tag, "_valid"}, cpu_dout_valid, 1'b0);
        check({tag, "_req"},   sdram_req, 1'b0);
        check({tag, "_we"},    sdram_we, 1'b0);
        check({tag, "_addr"},  sdram_addr, '0);
        check({tag, "_din"},   sdram_din, 8'h00);
        check({tag, "_tmo"},   timeout_err, 1'b0);
    endtask

    initial begin
        logic              r_rd;
        logic [ADDR_W-1:0] r_addr;
        int                r_ack;

        reset = 1'b1;
        idle_inputs();
        cpu_din = 8'h00; ram_addr = '0; sdram_dout = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1 reset = 1'b0;

        // Read miss, ack at N+3, then the cached repeat.
        access(1'b1, 1'b0, 1'b1, 1'b1, 27'h0002000, 8'h00, 3, 8'h5A, 0);
        access(1'b1, 1'b0, 1'b1, 1'b1, 27'h0002000, 8'h00, 1, 8'h11, 0);
        // Write-through invalidates; the following read misses.
        access(1'b0, 1'b1, 1'b1, 1'b1, 27'h0002000, 8'h77, 2, 8'h00, 0);
        access(1'b1, 1'b0, 1'b1, 1'b1, 27'h0002000, 8'h00, 1, 8'h77, 0);
        // ROM write and unmapped read are dropped.
        access(1'b0, 1'b1, 1'b1, 1'b0, 27'h0002000, 8'h33, 1, 8'h00, 0);
        access(1'b1, 1'b0, 1'b0, 1'b1, 27'h0005000, 8'h00, 1, 8'h44, 0);
        // No ack: abort, then the same address still misses.
        access(1'b1, 1'b0, 1'b1, 1'b1, 27'h0100000, 8'h00, 0, 8'h00, 0);
        access(1'b1, 1'b0, 1'b1, 1'b1, 27'h0100000, 8'h00, 2, 8'hC3, 0);
        // Flush while the read is in flight.
        access(1'b1, 1'b0, 1'b1, 1'b1, 27'h0004000, 8'h00, 3, 8'h96, 2);
        access(1'b1, 1'b0, 1'b1, 1'b1, 27'h0004000, 8'h00, 1, 8'h97, 0);

        // Reset in the middle of a read miss.
        flush_idle();
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_rd = 1'b1; ram_cs = 1'b1; ram_wr_en = 1'b1; ram_addr = 27'h0006000;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("req_before_reset", sdram_req, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("req_async_drop", sdram_req, 1'b0);
        check("wait_async_drop", cpu_wait, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        check_reset_values("midreset");
        access(1'b1, 1'b0, 1'b1, 1'b1, 27'h0006000, 8'h00, 2, 8'h5C, 0);

        // Randomized mix over a small address pool so hits and invalidates recur.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       r_addr = 27'h0002000;
                1:       r_addr = 27'h0002001;
                2:       r_addr = 27'h0004000;
                default: r_addr = ADDR_W'($urandom);
            endcase
            r_rd  = 1'($urandom_range(0, 1));
            r_ack = $urandom_range(1, 5);
            access(r_rd, !r_rd, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                   r_addr, 8'($urandom), r_ack, 8'($urandom),
                   ($urandom_range(0, 7) == 0) ? $urandom_range(1, r_ack) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
